ssd1306_spi_receiver: RTL

//   Receive-side counterpart of the SSD1306 4-wire SPI driver (SCLK/MOSI/DC/RES, optional CS).

---
 rtl/ssd1306_spi_receiver.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 4-wire SPI bus monitor: oversamples SCLK/MOSI/DC/CS/RES with i_Clk, rebuilds
// each byte with its DC tag and queues it in a first-word fall-through FIFO.
module ssd1306_spi_receiver #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int USE_CS      = 1
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_SPI_Clk,
    input  logic                          i_SPI_MOSI,
    input  logic                          i_SPI_DC,
    input  logic                          i_SPI_RES_L,
    input  logic                          i_SPI_CS_L,
    output logic [7:0]                    o_RX_Byte,
    output logic                          o_RX_DC,
    output logic                          o_RX_Valid,
    input  logic                          i_RX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count,
    output logic                          o_Overflow,
    input  logic                          i_Clear_Ovf,
    output logic                          o_Frame_Err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = 5;

    // Bit order of the synchronized bus: {RES_L, CS_L, DC, MOSI, SCLK}
    logic [SW-1:0] pin_in;
    logic [SW-1:0] synced;
    logic          cs_pin;

    assign cs_pin = (USE_CS != 0) ? i_SPI_CS_L : 1'b0;
    assign pin_in = {i_SPI_RES_L, cs_pin, i_SPI_DC, i_SPI_MOSI, i_SPI_Clk};

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_in[gi]};
                end
            end
            assign synced[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic sclk_s, mosi_s, dc_s, cs_s, res_s;
    assign {res_s, cs_s, dc_s, mosi_s, sclk_s} = synced;

    // Edge detection is only needed on SCLK and CS; MOSI/DC are sampled at the SCLK rise.
    logic [1:0] hist_reg;
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hist_reg <= '0;
        end else begin
            hist_reg <= {cs_s, sclk_s};
        end
    end

    logic sclk_rise, cs_rise, flush;
    assign sclk_rise = sclk_s & ~hist_reg[0] & ~cs_s & res_s;
    assign cs_rise   = cs_s & ~hist_reg[1];
    assign flush     = ~res_s;

    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       push_pend_reg;
    logic [8:0] push_data_reg;
    logic       frame_err_reg;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            push_pend_reg <= 1'b0;
            push_data_reg <= '0;
            frame_err_reg <= 1'b0;
        end else if (flush) begin
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            push_pend_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            push_pend_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            if (cs_rise) begin
                frame_err_reg <= (bit_cnt_reg != 3'd0);
                bit_cnt_reg   <= '0;
                shift_reg     <= '0;
            end else if (sclk_rise) begin
                shift_reg   <= {shift_reg[6:0], mosi_s};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    push_pend_reg <= 1'b1;
                    push_data_reg <= {dc_s, shift_reg[6:0], mosi_s};
                end
            end
        end
    end

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          ovf_reg;
    logic          pop, full, push_ok, drop;

    assign pop     = o_RX_Valid & i_RX_Ready;
    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign push_ok = push_pend_reg & (~full | pop) & ~flush;
    assign drop    = push_pend_reg & full & ~pop & ~flush;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    // Storage needs no reset: every read is masked by o_RX_Valid.
    always_ff @(posedge i_Clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data_reg;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            ovf_reg <= 1'b0;
        end else if (drop) begin
            ovf_reg <= 1'b1;
        end else if (i_Clear_Ovf) begin
            ovf_reg <= 1'b0;
        end
    end

    assign o_RX_Valid  = (count_reg != '0);
    assign o_RX_Byte   = o_RX_Valid ? mem[rd_ptr_reg][7:0] : 8'h00;
    assign o_RX_DC     = o_RX_Valid ? mem[rd_ptr_reg][8] : 1'b0;
    assign o_Count     = count_reg;
    assign o_Overflow  = ovf_reg;
    assign o_Frame_Err = frame_err_reg;
endmodule
